// File: rtl/gsensor_pkg.sv
// Shared constants, state type and address helpers for the G-sensor SPI responder.
package gsensor_pkg;

   localparam logic [5:0] ADDR_DEVID      = 6'h00;
   localparam logic [5:0] ADDR_BW_RATE    = 6'h2C;
   localparam logic [5:0] ADDR_INT_ENABLE = 6'h2E;
   localparam logic [5:0] ADDR_INT_SOURCE = 6'h30;
   localparam logic [5:0] ADDR_DATAX0     = 6'h32;
   localparam logic [5:0] ADDR_DATAX1     = 6'h33;
   localparam logic [5:0] ADDR_DATAY0     = 6'h34;
   localparam logic [5:0] ADDR_DATAY1     = 6'h35;
   localparam logic [5:0] ADDR_DATAZ0     = 6'h36;
   localparam logic [5:0] ADDR_DATAZ1     = 6'h37;

   localparam int CMD_RW_BIT         = 7;
   localparam int CMD_MB_BIT         = 6;
   localparam int INT_DATA_READY_BIT = 7;

   localparam logic [7:0] BW_RATE_RESET = 8'h0A;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      WR,
      RD
   } spi_resp_state_t;

   function automatic logic is_data_addr(input logic [5:0] addr);
      return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
   endfunction

   function automatic logic is_read_only(input logic [5:0] addr);
      return (addr == ADDR_DEVID) || (addr == ADDR_INT_SOURCE) || is_data_addr(addr);
   endfunction

endpackage

// File: rtl/gsensor_spi_responder_sync.sv
// Synchronizes the SPI pins into clk and produces one-cycle sclk/cs_n edge pulses.
module spi_input_sync
   import gsensor_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic spi_sclk,
   input  logic spi_cs_n,
   input  logic spi_sdi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic cs_n_s,
   output logic sdi_s
);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   cs_prev_q, cs_prev_d;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
      cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
   end

   // Idle levels: mode 3 sclk parks high, chip select deasserted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '1;
         cs_sync_q   <= '1;
         sdi_sync_q  <= '0;
         sclk_prev_q <= 1'b1;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         sdi_sync_q  <= sdi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
      end
   end

   assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
   assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
   assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
   assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 slave model of an ADXL345-style accelerometer: register file, sample capture, DATA_READY.
//
// state | meaning
// IDLE  | chip select high, waiting for a frame
// CMD   | shifting in the command byte
// WR    | shifting in write data bytes
// RD    | shifting out register bytes on spi_sdo
module gsensor_spi_responder
   import gsensor_pkg::*;
#(
   parameter logic [7:0] DEVID       = 8'hE5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   input  logic        sample_valid,
   input  logic        spi_sclk,
   input  logic        spi_cs_n,
   input  logic        spi_sdi,
   output logic        spi_sdo,
   output logic        spi_sdo_oe,
   output logic        int1,
   output logic        wr_strobe,
   output logic [5:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, sdi_s;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .spi_sclk  (spi_sclk),
      .spi_cs_n  (spi_cs_n),
      .spi_sdi   (spi_sdi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .cs_n_s    (cs_n_s),
      .sdi_s     (sdi_s)
   );

   spi_resp_state_t state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [6:0]      shift_in_q, shift_in_d;
   logic [7:0]      shift_out_q, shift_out_d;
   logic [5:0]      addr_q, addr_d;
   logic            mb_q, mb_d;
   logic [7:0]      regs_q [64];
   logic [7:0]      regs_d [64];
   logic [47:0]     pend_q, pend_d;
   logic            pend_valid_q, pend_valid_d;
   logic            sdo_q, sdo_d;
   logic            oe_q, oe_d;
   logic            int1_q, int1_d;
   logic            wr_strobe_q, wr_strobe_d;
   logic [5:0]      wr_addr_q, wr_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic            busy_q, busy_d;

   logic [7:0]      rx_byte;
   logic [5:0]      next_addr;
   logic [5:0]      load_addr;
   logic            load;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_in_d   = shift_in_q;
      shift_out_d  = shift_out_q;
      addr_d       = addr_q;
      mb_d         = mb_q;
      regs_d       = regs_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      sdo_d        = sdo_q;
      wr_strobe_d  = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      busy_d       = busy_q;
      rx_byte      = {shift_in_q, sdi_s};
      next_addr    = mb_q ? addr_q + 6'd1 : addr_q;
      load_addr    = addr_q;
      load         = 1'b0;

      if (cs_rise) begin
         state_d   = IDLE;
         bit_cnt_d = 3'd0;
         busy_d    = 1'b0;
         sdo_d     = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d   = CMD;
                  bit_cnt_d = 3'd0;
                  busy_d    = 1'b1;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  shift_in_d = rx_byte[6:0];
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     addr_d = rx_byte[5:0];
                     mb_d   = rx_byte[CMD_MB_BIT];
                     if (rx_byte[CMD_RW_BIT]) begin
                        state_d   = RD;
                        load      = 1'b1;
                        load_addr = rx_byte[5:0];
                     end else begin
                        state_d = WR;
                     end
                  end
               end
            end
            WR: begin
               if (sclk_rise) begin
                  shift_in_d = rx_byte[6:0];
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (!is_read_only(addr_q)) begin
                        regs_d[addr_q] = rx_byte;
                        wr_strobe_d    = 1'b1;
                        wr_addr_d      = addr_q;
                        wr_data_d      = rx_byte;
                     end
                     addr_d = next_addr;
                  end
               end
            end
            RD: begin
               if (sclk_fall) begin
                  sdo_d       = shift_out_q[7];
                  shift_out_d = {shift_out_q[6:0], 1'b0};
               end
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     addr_d    = next_addr;
                     load      = 1'b1;
                     load_addr = next_addr;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (load) begin
         shift_out_d = regs_q[load_addr];
         if (is_data_addr(load_addr)) regs_d[ADDR_INT_SOURCE][INT_DATA_READY_BIT] = 1'b0;
      end

      // Sample transfer is deferred while a frame is open so a burst read stays coherent.
      if (sample_valid) begin
         pend_d       = {sample_z, sample_y, sample_x};
         pend_valid_d = 1'b1;
      end
      if (!busy_q && pend_valid_d) begin
         regs_d[ADDR_DATAX0] = pend_d[7:0];
         regs_d[ADDR_DATAX1] = pend_d[15:8];
         regs_d[ADDR_DATAY0] = pend_d[23:16];
         regs_d[ADDR_DATAY1] = pend_d[31:24];
         regs_d[ADDR_DATAZ0] = pend_d[39:32];
         regs_d[ADDR_DATAZ1] = pend_d[47:40];
         regs_d[ADDR_INT_SOURCE][INT_DATA_READY_BIT] = 1'b1;
         pend_valid_d = 1'b0;
      end

      oe_d   = (state_d == RD) && !cs_n_s;
      int1_d = regs_q[ADDR_INT_SOURCE][INT_DATA_READY_BIT] & regs_q[ADDR_INT_ENABLE][INT_DATA_READY_BIT];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         shift_in_q   <= 7'd0;
         shift_out_q  <= 8'd0;
         addr_q       <= 6'd0;
         mb_q         <= 1'b0;
         for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
         regs_q[ADDR_DEVID]   <= DEVID;
         regs_q[ADDR_BW_RATE] <= BW_RATE_RESET;
         pend_q       <= 48'd0;
         pend_valid_q <= 1'b0;
         sdo_q        <= 1'b0;
         oe_q         <= 1'b0;
         int1_q       <= 1'b0;
         wr_strobe_q  <= 1'b0;
         wr_addr_q    <= 6'd0;
         wr_data_q    <= 8'd0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_in_q   <= shift_in_d;
         shift_out_q  <= shift_out_d;
         addr_q       <= addr_d;
         mb_q         <= mb_d;
         regs_q       <= regs_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         sdo_q        <= sdo_d;
         oe_q         <= oe_d;
         int1_q       <= int1_d;
         wr_strobe_q  <= wr_strobe_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         busy_q       <= busy_d;
      end
   end

   assign spi_sdo    = sdo_q;
   assign spi_sdo_oe = oe_q;
   assign int1       = int1_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;

endmodule
